// File: rtl/four_bit_adder.sv
// Parameterised ripple-carry adder for the E15 data/PC ALUs, with same-cycle
// combinational sum/flags and an optional enable-gated registered copy.
module four_bit_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             zero_q,
    output logic             ovf_q
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic prop;
        assign prop         = a[i] ^ b[i];
        assign sum[i]       = prop ^ carry[i];
        assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & prop);
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign cout = carry[WIDTH];
    assign ovf  = carry[WIDTH-1] ^ carry[WIDTH];
    assign zero = (sum == '0);

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             zero_d;
    logic             ovf_d;

    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (en) begin
            sum_d  = sum;
            cout_d = cout;
            zero_d = zero;
            ovf_d  = ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_four_bit_adder.sv
// Directed + exhaustive + randomized bench for four_bit_adder (WIDTH=4),
// checked against an integer-arithmetic reference model.
module tb_four_bit_adder;

    localparam int W   = 4;
    localparam int MOD = 2 ** W;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         en;
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;
    logic         ovf;
    logic [W-1:0] sum_q;
    logic         cout_q;
    logic         zero_q;
    logic         ovf_q;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_sum_q;
    int exp_cout_q;
    int exp_zero_q;
    int exp_ovf_q;

    four_bit_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .en    (en),
        .sum   (sum),
        .cout  (cout),
        .zero  (zero),
        .ovf   (ovf),
        .sum_q (sum_q),
        .cout_q(cout_q),
        .zero_q(zero_q),
        .ovf_q (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_signed(input int v);
        return (v >= MOD / 2) ? v - MOD : v;
    endfunction

    task automatic model(input int ai, input int bi, input int ci,
                         output int s, output int co, output int z, output int o);
        int u;
        int sv;
        u  = ai + bi + ci;
        s  = u % MOD;
        co = (u >= MOD) ? 1 : 0;
        z  = (s == 0) ? 1 : 0;
        sv = to_signed(ai) + to_signed(bi) + ci;
        o  = (sv > MOD / 2 - 1 || sv < -(MOD / 2)) ? 1 : 0;
    endtask

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_comb(input string tag);
        int s, co, z, o;
        model(int'(a), int'(b), int'(cin), s, co, z, o);
        check({tag, ".sum"},  int'(sum),  s);
        check({tag, ".cout"}, int'(cout), co);
        check({tag, ".zero"}, int'(zero), z);
        check({tag, ".ovf"},  int'(ovf),  o);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".sum_q"},  int'(sum_q),  exp_sum_q);
        check({tag, ".cout_q"}, int'(cout_q), exp_cout_q);
        check({tag, ".zero_q"}, int'(zero_q), exp_zero_q);
        check({tag, ".ovf_q"},  int'(ovf_q),  exp_ovf_q);
    endtask

    task automatic drive(input int ai, input int bi, input int ci);
        a   = W'(ai);
        b   = W'(bi);
        cin = ci[0];
        #1;
    endtask

    task automatic capture_model();
        int s, co, z, o;
        model(int'(a), int'(b), int'(cin), s, co, z, o);
        exp_sum_q  = s;
        exp_cout_q = co;
        exp_zero_q = z;
        exp_ovf_q  = o;
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        exp_sum_q  = 0;
        exp_cout_q = 0;
        exp_zero_q = 0;
        exp_ovf_q  = 0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_regs("reset");
        @(posedge clk);
        #1 check_regs("reset_hold");

        // Directed combinational vectors, with absolute expectations
        drive(5, 3, 0);
        check("add53.sum", int'(sum), 8);
        check("add53.cout", int'(cout), 0);
        check("add53.zero", int'(zero), 0);
        check("add53.ovf", int'(ovf), 1);
        drive(5, 12, 1);
        check("sub53.sum", int'(sum), 2);
        check("sub53.cout", int'(cout), 1);
        check("sub53.ovf", int'(ovf), 0);
        drive(3, 10, 1);
        check("sub35.sum", int'(sum), 14);
        check("sub35.cout", int'(cout), 0);
        drive(8, 8, 0);
        check("wrap88.sum", int'(sum), 0);
        check("wrap88.cout", int'(cout), 1);
        check("wrap88.zero", int'(zero), 1);
        check("wrap88.ovf", int'(ovf), 1);
        drive(15, 0, 1);
        check("wrapF1.sum", int'(sum), 0);
        check("wrapF1.cout", int'(cout), 1);
        check("wrapF1.zero", int'(zero), 1);
        check("wrapF1.ovf", int'(ovf), 0);
        drive(0, 14, 1);
        check("sub01.sum", int'(sum), 15);
        check("sub01.cout", int'(cout), 0);

        // Exhaustive sweep, comb outputs valid while held in reset
        for (int i = 0; i < MOD * MOD * 2; i++) begin
            drive(i % MOD, (i / MOD) % MOD, i / (MOD * MOD));
            check_comb("exh");
        end
        check_regs("reset_after_sweep");

        // Release reset between edges, then directed registered path
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        drive(2, 1, 0);
        @(posedge clk);
        #1;
        check("reg21.sum_q", int'(sum_q), 3);
        check("reg21.cout_q", int'(cout_q), 0);
        check("reg21.zero_q", int'(zero_q), 0);
        check("reg21.ovf_q", int'(ovf_q), 0);
        capture_model();

        @(negedge clk);
        en = 1'b0;
        drive(9, 9, 1);
        @(posedge clk);
        #1 check("hold.sum_q", int'(sum_q), 3);
        check_regs("hold");

        // Asynchronous reset mid-cycle
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.sum_q", int'(sum_q), 0);
        exp_sum_q  = 0;
        exp_cout_q = 0;
        exp_zero_q = 0;
        exp_ovf_q  = 0;
        check_regs("async_rst");
        drive(6, 7, 1);
        check("rst_comb.sum", int'(sum), 14);
        check_comb("rst_comb");
        en = 1'b1;
        @(posedge clk);
        #1 check_regs("rst_en_hold");
        @(negedge clk);
        rst_n = 1'b1;
        drive(7, 7, 0);
        @(posedge clk);
        #1;
        check("post_rst.sum_q", int'(sum_q), 14);
        check("post_rst.ovf_q", int'(ovf_q), 1);
        capture_model();
        check_regs("post_rst");

        // Randomized stream against the model
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            en = 1'($urandom_range(0, 1));
            drive(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
                  int'($urandom_range(0, 1)));
            check_comb("rnd");
            if (en) capture_model();
            @(posedge clk);
            #1 check_regs("rnd_reg");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/four_bit_adder.md
Name: four_bit_adder

Overview:
- WIDTH-bit (default 4) ripple-carry adder: the arithmetic core of the E15 data ALU and PC ALU.
- Combinational sum/carry outputs serve same-cycle ALU use. The ALU performs subtraction by feeding the inverted operand and carry-in = 1.
- An optional registered copy of the result and flags is provided for pipelined users. It runs on one clock with an asynchronous active-low reset.

Parameters:
- WIDTH, 4, operand/result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock for the registered outputs only.
- rst_n  input  1  asynchronous active-low reset for the registered outputs.
- a  input  WIDTH  first addend.
- b  input  WIDTH  second addend (the caller inverts it for subtraction).
- cin  input  1  carry-in into bit 0.
- en  input  1  capture enable for the registered outputs.
- sum  output  WIDTH  combinational (a + b + cin) mod 2^WIDTH.
- cout  output  1  combinational carry out of the MSB.
- zero  output  1  combinational; 1 when sum == 0.
- ovf  output  1  combinational signed overflow, equal to carry into MSB XOR carry out of MSB.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered cout.
- zero_q  output  1  registered zero.
- ovf_q  output  1  registered ovf.

Behaviour:
- Structure:
  - WIDTH full-adder cells chained via a generate loop.
  - Each cell: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = cin.
  - cout = c[WIDTH]; ovf = c[WIDTH-1]^c[WIDTH].
- Combinational path:
  - sum, cout, zero, ovf have zero latency and settle within the same cycle.
  - They do not depend on clk, rst_n or en, and they stay valid during reset.
- Arithmetic:
  - {cout,sum} = a + b + cin, exact over WIDTH+1 bits, so the result wraps modulo 2^WIDTH.
  - Subtraction convention: a - x is computed with b = ~x, cin = 1. Then cout = 1 means no borrow (a >= x unsigned).
  - Example: 0 - 1 yields sum = all ones, cout = 0.
- Registered path:
  - On rst_n falling, asynchronously and immediately: sum_q = 0, cout_q = 0, zero_q = 0, ovf_q = 0.
  - While rst_n = 0, registers hold these values regardless of clk or en.
  - On a rising clk with rst_n = 1 and en = 1: capture sum, cout, zero, ovf. Latency is 1 cycle.
  - On a rising clk with en = 0: hold the previous values.
  - Reset asserted mid-stream clears the registers at once. The first capture after release occurs on the first rising edge with rst_n = 1 and en = 1.
- No X propagation from registers after reset. The combinational outputs must be X-free for any known inputs.

Test Plan:
- Add, no carry: a=0101, b=0011, cin=0 -> sum=1000, cout=0, zero=0, ovf=1 (5+3 overflows signed 4-bit).
- Subtract: a=0101, b=~0011=1100, cin=1 -> sum=0010, cout=1, zero=0, ovf=0. Then a=0011, b=~0101=1010, cin=1 -> sum=1110, cout=0.
- Wrap to zero: a=1000, b=1000, cin=0 -> sum=0000, cout=1, zero=1, ovf=1. Also a=1111, b=0000, cin=1 -> sum=0000, cout=1, zero=1, ovf=0.
- Exhaustive: all 512 combinations of (a, b, cin) for WIDTH=4 -> {cout,sum} == a+b+cin; zero and ovf match the definitions above.
- Registered path:
  - en=1, a=0010, b=0001, cin=0 -> after one rising edge sum_q=0011, cout_q=0, zero_q=0.
  - With en=0 and new inputs, sum_q holds 0011.
- Reset: drive rst_n=0 between clock edges while sum_q=0011 -> sum_q/cout_q/zero_q/ovf_q go to 0 immediately, before any edge. The combinational sum still tracks the inputs. After release, the first en=1 edge captures again.
